// File: rtl/regfile_pkg.sv
// Shared register-file types and sizes for the integer register file and its write-back path.
package regfile_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned N_REGS = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, then moves the
// pointer one past the winner. Grants only while en is high.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int unsigned IdxW = $clog2(N);

  logic [IdxW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned     cand;
    logic [IdxW-1:0] c;
    cand      = 0;
    c         = '0;
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = k + {{(32-IdxW){1'b0}}, ptr_q};
      if (cand >= N) cand = cand - N;
      c = IdxW'(cand);
      if (en && !gnt_valid && req[c]) begin
        gnt_valid = 1'b1;
        gnt_idx   = c;
        gnt[c]    = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid) begin
      ptr_d = (gnt_idx == IdxW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port; one round-robin grant per cycle.
// Define REGFILE_WB_FWD_EN to add the in-flight write forwarding mux on both read ports.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [REG_AW*N_REQ-1:0] req_rd,
  input  logic [XLEN*N_REQ-1:0]   req_data,
  input  logic                    wb_stall,
  output logic                    wb_write,
  output logic [REG_AW-1:0]       wb_rw,
  output logic [XLEN-1:0]         wb_rwd
`ifdef REGFILE_WB_FWD_EN
  ,
  input  logic [REG_AW-1:0]       rs1,
  input  logic [REG_AW-1:0]       rs2,
  input  logic [XLEN-1:0]         rf_rd1,
  input  logic [XLEN-1:0]         rf_rd2,
  output logic [XLEN-1:0]         fwd_rd1,
  output logic [XLEN-1:0]         fwd_rd2
`endif
);

  logic [N_REQ-1:0]         gnt;
  logic                     gnt_valid;
  logic [$clog2(N_REQ)-1:0] gnt_idx;
  reg_addr_t                sel_rd;
  xlen_t                    sel_data;

  logic      wb_write_q;
  reg_addr_t wb_rw_q;
  xlen_t     wb_rwd_q;

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .en        (!wb_stall && !reset),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign req_ready = gnt;
  assign sel_rd    = req_rd[REG_AW*gnt_idx +: REG_AW];
  assign sel_data  = req_data[XLEN*gnt_idx +: XLEN];

  // Address and data hold when idle; only the write strobe drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_write_q <= 1'b0;
      wb_rw_q    <= '0;
      wb_rwd_q   <= '0;
    end else if (gnt_valid) begin
      wb_write_q <= (sel_rd != '0);
      wb_rw_q    <= sel_rd;
      wb_rwd_q   <= sel_data;
    end else begin
      wb_write_q <= 1'b0;
    end
  end

  assign wb_write = wb_write_q;
  assign wb_rw    = wb_rw_q;
  assign wb_rwd   = wb_rwd_q;

`ifdef REGFILE_WB_FWD_EN
  assign fwd_rd1 = (wb_write_q && wb_rw_q == rs1 && rs1 != '0) ? wb_rwd_q : rf_rd1;
  assign fwd_rd2 = (wb_write_q && wb_rw_q == rs2 && rs2 != '0) ? wb_rwd_q : rf_rd2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_regfile_wb_arbiter;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [5*N-1:0]  req_rd;
  logic [32*N-1:0] req_data;
  logic            wb_stall;
  logic            wb_write;
  logic [4:0]      wb_rw;
  logic [31:0]     wb_rwd;
`ifdef REGFILE_WB_FWD_EN
  logic [4:0]      rs1 = '0, rs2 = '0;
  logic [31:0]     rf_rd1 = '0, rf_rd2 = '0;
  logic [31:0]     fwd_rd1, fwd_rd2;
`endif

  regfile_wb_arbiter #(
    .N_REQ(N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .wb_stall  (wb_stall),
    .wb_write  (wb_write),
    .wb_rw     (wb_rw),
    .wb_rwd    (wb_rwd)
`ifdef REGFILE_WB_FWD_EN
    ,
    .rs1       (rs1),
    .rs2       (rs2),
    .rf_rd1    (rf_rd1),
    .rf_rd2    (rf_rd2),
    .fwd_rd1   (fwd_rd1),
    .fwd_rd2   (fwd_rd2)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int          m_ptr   = 0;
  logic        m_write = 1'b0;
  logic [4:0]  m_rw    = '0;
  logic [31:0] m_rwd   = '0;
  int          last_g  = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check grant, advance model.
  task automatic step(input logic [N-1:0] v, input logic [5*N-1:0] rd,
                      input logic [32*N-1:0] d, input logic st, input logic rst);
    int           g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    check("wb_write", 32'(wb_write), 32'(m_write));
    check("wb_rw", 32'(wb_rw), 32'(m_rw));
    check("wb_rwd", wb_rwd, m_rwd);
    req_valid = v;
    req_rd    = rd;
    req_data  = d;
    wb_stall  = st;
    reset     = rst;
    #1;
    g = (rst || st) ? -1 : pick(v, m_ptr);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
`ifdef REGFILE_WB_FWD_EN
    check("fwd_rd1", fwd_rd1, (m_write && m_rw == rs1 && rs1 != 0) ? m_rwd : rf_rd1);
    check("fwd_rd2", fwd_rd2, (m_write && m_rw == rs2 && rs2 != 0) ? m_rwd : rf_rd2);
`endif
    last_g = g;
    if (rst) begin
      m_write = 1'b0;
      m_rw    = '0;
      m_rwd   = '0;
      m_ptr   = 0;
    end else if (g >= 0) begin
      m_rw    = rd[5*g +: 5];
      m_rwd   = d[32*g +: 32];
      m_write = (m_rw != 0);
      m_ptr   = (g + 1) % N;
    end else begin
      m_write = 1'b0;
    end
  endtask

  logic            off_v [N];
  logic [4:0]      off_rd[N];
  logic [31:0]     off_d [N];
  logic [N-1:0]    pv;
  logic [5*N-1:0]  prd;
  logic [32*N-1:0] pd;

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    wb_stall  = 1'b0;
    repeat (2) @(posedge clk);

    // Reset with all requesters valid, then first grant goes to 0
    step(3'b111, '0, '0, 1'b0, 1'b1);
    step(3'b111, '0, '0, 1'b0, 1'b1);
    check("rst_ready", 32'(req_ready), 32'h0);
    step(3'b111, '0, '0, 1'b0, 1'b0);
    check("first_gnt", 32'(req_ready), 32'h1);

    // Single request
    step('0, '0, '0, 1'b0, 1'b1);
    step(3'b001, 15'd5, {64'h0, 32'hDEADBEEF}, 1'b0, 1'b0);
    check("single_rdy", 32'(req_ready), 32'h1);
    step('0, '0, '0, 1'b0, 1'b0);
    check("single_wr", 32'(wb_write), 32'h1);
    check("single_rw", 32'(wb_rw), 32'd5);
    check("single_rwd", wb_rwd, 32'hDEADBEEF);
    step('0, '0, '0, 1'b0, 1'b0);
    check("single_wr_off", 32'(wb_write), 32'h0);

    // Fairness: all valid for 9 cycles
    step('0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      step(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0, 1'b0);
      check("fair_gnt", 32'(req_ready), 32'(1 << (k % 3)));
    end

    // Write to x0 is consumed, no write strobe, pointer advances to 2
    step('0, '0, '0, 1'b0, 1'b1);
    step(3'b010, '0, {32'h0, 32'h1234, 32'h0}, 1'b0, 1'b0);
    check("x0_rdy", 32'(req_ready), 32'h2);
    step(3'b111, {5'd9, 5'd9, 5'd9}, '0, 1'b0, 1'b0);
    check("x0_wr", 32'(wb_write), 32'h0);
    check("x0_ptr", 32'(req_ready), 32'h4);

    // Stall holds off req2 for 3 cycles, grant on release
    step('0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(3'b100, {5'd4, 10'd0}, {32'h44, 64'h0}, 1'b1, 1'b0);
      check("stall_rdy", 32'(req_ready), 32'h0);
    end
    step(3'b100, {5'd4, 10'd0}, {32'h44, 64'h0}, 1'b0, 1'b0);
    check("stall_wr", 32'(wb_write), 32'h0);
    check("release_rdy", 32'(req_ready), 32'h4);

`ifdef REGFILE_WB_FWD_EN
    step(3'b001, 15'd7, {64'h0, 32'hA5A5A5A5}, 1'b0, 1'b0);
    rs1 = 5'd7; rs2 = 5'd8; rf_rd1 = 32'h0; rf_rd2 = 32'h11112222;
    step('0, '0, '0, 1'b0, 1'b0);
    check("fwd1_hit", fwd_rd1, 32'hA5A5A5A5);
    check("fwd2_miss", fwd_rd2, 32'h11112222);
    rs1 = 5'd0; rf_rd1 = 32'h0;
    step(3'b010, {5'd0, 5'd0, 5'd0}, '0, 1'b0, 1'b0);
    check("fwd1_x0", fwd_rd1, 32'h0);
`endif

    // Randomized traffic with requester protocol: hold until accepted, occasional withdraw
    for (int i = 0; i < N; i++) off_v[i] = 1'b0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_g == i) off_v[i] = 1'b0;
        if (!off_v[i] && ($urandom % 2 == 0)) begin
          off_v[i]  = 1'b1;
          off_rd[i] = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
          off_d[i]  = $urandom;
        end else if (off_v[i] && ($urandom % 12 == 0)) begin
          off_v[i] = 1'b0;
        end
        pv[i]           = off_v[i];
        prd[5*i +: 5]   = off_rd[i];
        pd[32*i +: 32]  = off_d[i];
      end
`ifdef REGFILE_WB_FWD_EN
      rs1 = ($urandom % 2 == 0) ? m_rw : 5'($urandom);
      rs2 = 5'($urandom);
      rf_rd1 = $urandom;
      rf_rd2 = $urandom;
`endif
      step(pv, prd, pd, ($urandom % 5 == 0), ($urandom % 40 == 0));
      if (reset) begin
        for (int i = 0; i < N; i++) off_v[i] = 1'b0;
      end
    end
    step('0, '0, '0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
